// File: rtl/pe_inst_seq_if.sv
// Host/PE-side signal bundle of the instruction sequencer.
// master = host driving loads and run control, slave = the sequencer.
interface pe_inst_seq_if #(
  parameter int INST_DWIDTH = 72,
  parameter int INST_AWIDTH = 10
);
  logic                   Load_En;
  logic [INST_AWIDTH-1:0] Load_Addr;
  logic [INST_DWIDTH-1:0] Load_Data;
  logic                   Load_Err;
  logic                   Start;
  logic                   Abort;
  logic [INST_AWIDTH:0]   Inst_Count;
  logic [INST_DWIDTH-1:0] Inst_Mem_Out;
  logic                   PE_Array_Busy;
  logic                   Done;

  modport master (
    output Load_En, Load_Addr, Load_Data, Start, Abort, Inst_Count,
    input  Load_Err, Inst_Mem_Out, PE_Array_Busy, Done
  );

  modport slave (
    input  Load_En, Load_Addr, Load_Data, Start, Abort, Inst_Count,
    output Load_Err, Inst_Mem_Out, PE_Array_Busy, Done
  );
endinterface

// File: rtl/pe_inst_seq.sv
// Instruction sequencer for a PE array: holds a program store loaded by the
// host, streams N words out on Start, keeps the array busy for a drain
// window afterwards and signals completion with a one-cycle Done pulse.
module pe_inst_seq #(
  parameter int INST_DWIDTH  = 72,
  parameter int INST_AWIDTH  = 10,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic          Clk,
  input  logic          Resetn,
  pe_inst_seq_if.slave  bus
);

  localparam int DEPTH = 1 << INST_AWIDTH;
  localparam logic [INST_AWIDTH:0] N_MAX  = {1'b1, {INST_AWIDTH{1'b0}}};
  localparam logic [INST_AWIDTH:0] N_ONE  = {{INST_AWIDTH{1'b0}}, 1'b1};
  localparam logic [INST_AWIDTH:0] N_ZERO = {(INST_AWIDTH+1){1'b0}};
  localparam logic [7:0]           DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INST_AWIDTH:0]   r_n;
  logic [INST_AWIDTH:0]   w_n_nxt;
  logic [INST_AWIDTH:0]   r_cnt;
  logic [INST_AWIDTH:0]   w_cnt_nxt;
  logic [INST_AWIDTH:0]   w_n_sat;
  logic [7:0]             r_drain;
  logic [7:0]             w_drain_nxt;
  logic                   w_issue;
  logic                   w_load_ok;
  logic [INST_DWIDTH-1:0] r_mem [DEPTH];
  logic [INST_DWIDTH-1:0] r_out;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_load_err;

  // Host writes are only safe while no program is being streamed.
  assign w_load_ok = (r_state == S_IDLE) || (r_state == S_DONE);

  // Counts larger than the store wrap nothing: they clamp to the full depth.
  assign w_n_sat = (bus.Inst_Count > N_MAX) ? N_MAX : bus.Inst_Count;

  // Next-state, counter and read-issue decode; Abort overrides everything in RUN/DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          if (w_n_sat == N_ZERO) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
            w_n_nxt     = w_n_sat;
            w_cnt_nxt   = N_ZERO;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.Abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = N_ZERO;
        end else begin
          w_issue = 1'b1;
          if (r_cnt == (r_n - N_ONE)) begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = N_ZERO;
            w_drain_nxt = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + N_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (bus.Abort) begin
          w_state_nxt = S_IDLE;
          w_drain_nxt = 8'd0;
        end else if (r_drain == DRAIN_LAST) begin
          w_state_nxt = S_DONE;
          w_drain_nxt = 8'd0;
        end else begin
          w_drain_nxt = r_drain + 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = N_ZERO;
        w_drain_nxt = 8'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_n     <= N_ZERO;
      r_cnt   <= N_ZERO;
      r_drain <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Program store write port; contents are deliberately not reset.
  always_ff @(posedge Clk) begin
    if (bus.Load_En && w_load_ok) begin
      r_mem[bus.Load_Addr] <= bus.Load_Data;
    end
  end

  // Registered read port doubles as the instruction output; idle cycles emit NOP (zero).
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_out <= '0;
    end else if (w_issue) begin
      r_out <= r_mem[r_cnt[INST_AWIDTH-1:0]];
    end else begin
      r_out <= '0;
    end
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done     <= (w_state_nxt == S_DONE);
      r_load_err <= bus.Load_En && !w_load_ok;
    end
  end

  assign bus.Inst_Mem_Out  = r_out;
  assign bus.PE_Array_Busy = r_busy;
  assign bus.Done          = r_done;
  assign bus.Load_Err      = r_load_err;

endmodule

// File: tb/tb_pe_inst_seq.sv
// Self-checking bench for pe_inst_seq: directed scenarios with literal
// expectations plus randomized traffic against a cycle-window model.
module tb_pe_inst_seq;

  localparam int DW    = 72;
  localparam int AW    = 4;
  localparam int D     = 8;
  localparam int DEPTH = 16;

  logic Clk = 1'b0;
  logic Resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  pe_inst_seq_if #(.INST_DWIDTH(DW), .INST_AWIDTH(AW)) bus ();

  pe_inst_seq #(.INST_DWIDTH(DW), .INST_AWIDTH(AW), .DRAIN_CYCLES(D)) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run accepted at cycle T with N words occupies cycles T+1..end; outputs
  // follow directly from window arithmetic on T, N and D.
  int             cyc = 0;
  bit             m_active = 1'b0;
  int             m_t = 0;
  int             m_n = 0;
  logic [DW-1:0]  m_mem [DEPTH];
  logic [DW-1:0]  e_out = '0;
  logic           e_busy = 1'b0;
  logic           e_done = 1'b0;
  logic           e_lerr = 1'b0;

  function automatic int end_cyc();
    return (m_n == 0) ? m_t + 1 : m_t + m_n + D + 1;
  endfunction

  // Per-cycle compare against the model, then advance the model with this cycle's inputs.
  always @(negedge Clk) begin
    bit is_idle, is_done, is_busy;
    int n1, k, cnt;
    if (!Resetn) begin
      chk_b("rst_busy", bus.PE_Array_Busy, 1'b0);
      chk_b("rst_done", bus.Done, 1'b0);
      chk_b("rst_lerr", bus.Load_Err, 1'b0);
      chk_w("rst_out", bus.Inst_Mem_Out, '0);
      m_active = 1'b0;
      e_out = '0; e_busy = 1'b0; e_done = 1'b0; e_lerr = 1'b0;
    end else begin
      chk_b("cyc_busy", bus.PE_Array_Busy, e_busy);
      chk_b("cyc_done", bus.Done, e_done);
      chk_b("cyc_lerr", bus.Load_Err, e_lerr);
      chk_w("cyc_out", bus.Inst_Mem_Out, e_out);
      is_idle = !m_active || (cyc > end_cyc());
      is_done = m_active && (cyc == end_cyc());
      is_busy = m_active && (cyc < end_cyc());
      e_lerr = 1'b0;
      if (bus.Load_En) begin
        if (is_idle || is_done) m_mem[bus.Load_Addr] = bus.Load_Data;
        else e_lerr = 1'b1;
      end
      if (is_busy && bus.Abort) begin
        m_active = 1'b0;
      end else if (is_idle && bus.Start) begin
        cnt = int'(bus.Inst_Count);
        m_active = 1'b1;
        m_t = cyc;
        m_n = (cnt > DEPTH) ? DEPTH : cnt;
      end
      n1 = cyc + 1;
      if (m_active) begin
        e_busy = (m_n > 0) && (n1 >= m_t + 1) && (n1 <= m_t + m_n + D);
        e_done = (n1 == end_cyc());
        k = n1 - m_t - 2;
        e_out = (k >= 0 && k < m_n) ? m_mem[k] : '0;
      end else begin
        e_busy = 1'b0; e_done = 1'b0; e_out = '0;
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    bus.Load_En = 1'b1;
    bus.Load_Addr = AW'(a);
    bus.Load_Data = d;
    tick();
    bus.Load_En = 1'b0;
  endtask

  // Drives Start in the current cycle T; returns positioned in cycle T+1.
  task automatic start(input int cnt);
    bus.Start = 1'b1;
    bus.Inst_Count = (AW+1)'(cnt);
    tick();
    bus.Start = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0;
    bus.Load_En = 1'b0; bus.Load_Addr = '0; bus.Load_Data = '0;
    bus.Start = 1'b0; bus.Abort = 1'b0; bus.Inst_Count = '0;
    repeat (3) tick();
    Resetn = 1'b1;
    tick();
    @(negedge Clk);
    chk_b("reset_busy", bus.PE_Array_Busy, 1'b0);
    chk_b("reset_done", bus.Done, 1'b0);
    chk_w("reset_out", bus.Inst_Mem_Out, '0);
    tick();

    // fill the whole store with known words
    for (int i = 0; i < DEPTH; i++) load(i, DW'(32'h5A00 + i));

    // basic run: words 0x11..0x44, count 4
    for (int i = 0; i < 4; i++) load(i, DW'(17 * (i + 1)));
    start(4);
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      chk_b("basic_busy", bus.PE_Array_Busy, k <= 12);
      chk_b("basic_done", bus.Done, k == 13);
      chk_w("basic_out", bus.Inst_Mem_Out, (k >= 2 && k <= 5) ? DW'(17 * (k - 1)) : '0);
      tick();
    end

    // count zero: Done next cycle, never busy
    start(0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk);
      chk_b("zero_done", bus.Done, k == 1);
      chk_b("zero_busy", bus.PE_Array_Busy, 1'b0);
      chk_w("zero_out", bus.Inst_Mem_Out, '0);
      tick();
    end

    // load while busy is rejected and leaves the store alone
    start(4);
    tick(); tick();
    bus.Load_En = 1'b1; bus.Load_Addr = AW'(1); bus.Load_Data = DW'(32'hAB);
    tick();
    bus.Load_En = 1'b0;
    @(negedge Clk);
    chk_b("busyload_err", bus.Load_Err, 1'b1);
    tick();
    @(negedge Clk);
    chk_b("busyload_err_clr", bus.Load_Err, 1'b0);
    repeat (12) tick();
    start(4);
    tick(); tick();
    @(negedge Clk);
    chk_w("busyload_word1", bus.Inst_Mem_Out, DW'(32'h22));
    repeat (14) tick();

    // abort at T+3 of a 10-word run
    for (int i = 4; i < 10; i++) load(i, DW'(32'h1111 * i));
    start(10);
    tick(); tick();
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    for (int k = 4; k <= 22; k++) begin
      @(negedge Clk);
      chk_b("abort_busy", bus.PE_Array_Busy, 1'b0);
      chk_b("abort_done", bus.Done, 1'b0);
      chk_w("abort_out", bus.Inst_Mem_Out, '0);
      tick();
    end
    start(1);
    @(negedge Clk);
    chk_b("abort_restart_busy", bus.PE_Array_Busy, 1'b1);
    tick();
    repeat (12) tick();

    // Start during DRAIN is ignored: exactly one Done
    start(2);
    repeat (4) tick();
    bus.Start = 1'b1; bus.Inst_Count = (AW+1)'(3);
    tick();
    bus.Start = 1'b0;
    for (int k = 6; k <= 22; k++) begin
      @(negedge Clk);
      chk_b("drainstart_busy", bus.PE_Array_Busy, k <= 10);
      chk_b("drainstart_done", bus.Done, k == 11);
      tick();
    end

    // count 20 saturates to 16 words
    start(20);
    for (int k = 1; k <= 27; k++) begin
      @(negedge Clk);
      chk_b("sat_busy", bus.PE_Array_Busy, k <= 24);
      chk_b("sat_done", bus.Done, k == 25);
      if (k == 17) chk_w("sat_last", bus.Inst_Mem_Out, DW'(32'h5A0F));
      if (k == 18) chk_w("sat_after", bus.Inst_Mem_Out, '0);
      tick();
    end

    // reset mid-run at T+2
    start(10);
    tick();
    Resetn = 1'b0;
    #1;
    chk_w("midrst_out", bus.Inst_Mem_Out, '0);
    chk_b("midrst_busy", bus.PE_Array_Busy, 1'b0);
    chk_b("midrst_done", bus.Done, 1'b0);
    tick(); tick();
    Resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      chk_b("postrst_busy", bus.PE_Array_Busy, 1'b0);
      chk_b("postrst_done", bus.Done, 1'b0);
      tick();
    end
    start(2);
    @(negedge Clk);
    chk_b("postrst_start", bus.PE_Array_Busy, 1'b1);
    tick();
    repeat (12) tick();

    // randomized traffic, checked by the per-cycle model
    for (int i = 0; i < 1500; i++) begin
      bus.Start      = ($urandom_range(0, 7) == 0);
      bus.Inst_Count = (AW+1)'($urandom_range(0, 20));
      bus.Load_En    = ($urandom_range(0, 3) == 0);
      bus.Load_Addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.Load_Data  = DW'({$urandom(), $urandom(), $urandom()});
      bus.Abort      = ($urandom_range(0, 39) == 0);
      tick();
    end
    bus.Start = 1'b0; bus.Load_En = 1'b0; bus.Abort = 1'b0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_inst_seq.md
PE_INST_SEQ -- requirements
Module: pe_inst_seq

Interface
REQ-001 SHALL have parameter INST_DWIDTH, default 72, instruction word width.
REQ-002 SHALL have parameter INST_AWIDTH, default 10, instruction store address width (depth 2^INST_AWIDTH).
REQ-003 SHALL have parameter DRAIN_CYCLES, default 8, legal range 1..255, post-issue cycles that keep the array busy.
REQ-004 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port Resetn  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port Load_En  input  1  host write strobe into the instruction store.
REQ-007 SHALL have port Load_Addr  input  INST_AWIDTH  host write address.
REQ-008 SHALL have port Load_Data  input  INST_DWIDTH  host write data.
REQ-009 SHALL have port Load_Err  output  1  one-cycle pulse: write rejected.
REQ-010 SHALL have port Start  input  1  one-cycle request to run a program.
REQ-011 SHALL have port Abort  input  1  terminate the current run.
REQ-012 SHALL have port Inst_Count  input  INST_AWIDTH+1  number of instructions to issue, sampled with Start.
REQ-013 SHALL have port Inst_Mem_Out  output  INST_DWIDTH  registered instruction stream to the PE.
REQ-014 SHALL have port PE_Array_Busy  output  1  high while a program executes.
REQ-015 SHALL have port Done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL hold a 2^INST_AWIDTH x INST_DWIDTH store: synchronous write, registered read, one-cycle read latency.
REQ-017 SHALL implement the states IDLE, RUN, DRAIN and DONE; the state after reset SHALL be IDLE.
REQ-018 SHALL write Load_Data to Load_Addr when Load_En=1 in IDLE or DONE, and SHALL ignore it otherwise, pulsing Load_Err the next cycle.
REQ-019 SHALL, for Start=1 in IDLE at cycle T with N=Inst_Count>0, latch N and enter RUN at T+1.
REQ-020 SHALL saturate N to 2^INST_AWIDTH when Inst_Count exceeds the store depth.
REQ-021 SHALL, in RUN, issue read addresses 0..N-1 on cycles T+1..T+N, then enter DRAIN.
REQ-022 SHALL drive Inst_Mem_Out = word k at cycle T+2+k for k = 0..N-1, and all-zero (NOP: Wea=Web=0) at every other cycle.
REQ-023 SHALL remain in DRAIN for exactly DRAIN_CYCLES cycles, then enter DONE for one cycle, then return to IDLE.
REQ-024 SHALL assert PE_Array_Busy exactly in RUN and DRAIN (T+1 .. T+N+DRAIN_CYCLES).
REQ-025 SHALL assert Done exactly in the DONE cycle (T+N+DRAIN_CYCLES+1), with PE_Array_Busy=0 in that cycle.
REQ-026 SHALL ignore Start when the state is not IDLE.
REQ-027 SHALL, for Start with Inst_Count=0, go to DONE at T+1 (Done pulse), with no Busy and no non-zero output.
REQ-028 SHALL, for a same-cycle Load_En and Start in IDLE, complete the write and start the run; a write to address 0 SHALL be visible as word 0.
REQ-029 SHALL, on Abort=1 in RUN or DRAIN, enter IDLE next cycle with Busy=0, Inst_Mem_Out=0 from that cycle, and no Done; Abort SHALL have priority over all other events.
REQ-030 SHALL ignore Abort in IDLE and DONE.

Reset
REQ-031 SHALL, on Resetn=0, asynchronously force: state IDLE; Inst_Mem_Out=0; PE_Array_Busy=0; Done=0; Load_Err=0; counters 0.
REQ-032 SHALL leave store contents unspecified after reset; reset mid-run SHALL abort with no Done after release.

Verification
REQ-033 SHALL verify basic run: load words 0..3 = 0x11..0x44, Start with count 4, DRAIN_CYCLES=8 at T -> outputs 0x11..0x44 at T+2..T+5, Busy for T+1..T+12, Done at T+13.
REQ-034 SHALL verify count 0: Start with count 0 -> Done at T+1, Busy never high, Inst_Mem_Out stays 0.
REQ-035 SHALL verify load while busy: Load_En at T+3 of a run -> Load_Err at T+4, store word unchanged on a rerun.
REQ-036 SHALL verify Abort: Abort at T+3 of a 10-word run -> Busy=0 and output 0 at T+4, no Done, and a following Start is accepted.
REQ-037 SHALL verify start while busy and saturation: a Start during DRAIN is ignored (single Done); with INST_AWIDTH=4, count 20 issues 16 words.
REQ-038 SHALL verify reset mid-run: Resetn low at T+2 -> all outputs 0 immediately, state IDLE after release.
